// File: rtl/dlsc_pcie_s6_outbound_read_cpl_pt.sv
// Outbound PCIe read completion receiver with per-tag timeout ages.
// Optional feature macro: DLSC_PCIE_CPL_POISON_DATA_EN (poisoned/errored SC completions stream as SLVERR data).
module dlsc_pcie_s6_outbound_read_cpl_pt #(
  parameter int TAG     = 5,
  parameter int TIMEOUT = 625000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic           rx_ready_o,
  input  logic           rx_valid_i,
  input  logic [31:0]    rx_data_i,
  input  logic           rx_last_i,
  input  logic           rx_err_i,
  input  logic           err_ready_i,
  output logic           err_valid_o,
  output logic           err_unexpected_o,
  output logic           err_timeout_o,
  output logic [TAG-1:0] err_tag_o,
  input  logic           cpl_ready_i,
  output logic           cpl_valid_o,
  output logic           cpl_last_o,
  output logic [31:0]    cpl_data_o,
  output logic [1:0]     cpl_resp_o,
  output logic [TAG-1:0] cpl_tag_o,
  input  logic           alloc_init_i,
  input  logic           alloc_valid_i,
  input  logic [TAG:0]   alloc_tag_i,
  input  logic [9:0]     alloc_len_i,
  input  logic [4:0]     alloc_addr_i,
  output logic           dealloc_cplh_o,
  output logic           dealloc_cpld_o,
  input  logic           rcb_i
);

  localparam int TAGS = 2**TAG;
  localparam int TDIV = TIMEOUT / 4;
  localparam int PW   = (TDIV > 1) ? $clog2(TDIV) : 1;

  typedef enum logic [2:0] {S_H0, S_H1, S_H2, S_DATA, S_ERROR, S_FLUSH, S_TIMEOUT} state_t;
  typedef struct packed {
    logic       valid;
    logic       last;
    logic [4:0] addr;
    logic [9:0] len;
  } tag_entry_t;

  state_t         st_q;
  logic [TAG-1:0] cur_tag_q, err_tag_q, rd_idx, alloc_idx, exp_idx;
  logic           ep_q, err_q, sc_q, bcm_q, last_seen_q;
  logic [11:0]    bc_q;
  logic           err_valid_q, err_unexp_q, err_to_q, cplh_q, cpld_q;
  logic [PW-1:0]  presc_q, presc_d;
  logic           tick;
  logic [1:0]     age_q [TAGS];
  logic [TAGS-1:0] exp_q, pend_q;
  tag_entry_t     mem [TAGS];
  tag_entry_t     ent;
  logic [7:0]     rx_tag;
  logic           alloc_we, hit, data_ok, hdr_bad, poison, rx_fire, cpl_fire;
  logic           set_unexp, set_to, any_exp;

  assign rx_tag    = rx_data_i[15:8];
  assign rd_idx    = (st_q == S_H2) ? rx_tag[TAG-1:0] : cur_tag_q;
  assign ent       = mem[rd_idx];
  assign alloc_idx = alloc_tag_i[TAG-1:0];
  // Tag values outside the tracked range are never written.
  assign alloc_we  = alloc_valid_i && !alloc_tag_i[TAG];
  assign hdr_bad   = ep_q || err_q || rx_err_i;
  assign hit       = !alloc_valid_i && ent.valid && ((rx_tag >> TAG) == 8'd0) &&
                     (rx_data_i[1:0] == 2'b00) && (rx_data_i[6:2] == ent.addr) &&
                     (bc_q[1:0] == 2'b00) && (bcm_q || (bc_q[11:2] == ent.len));

`ifdef DLSC_PCIE_CPL_POISON_DATA_EN
  logic poison_q;
  assign data_ok = hit && sc_q;
  assign poison  = poison_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) poison_q <= 1'b0;
    else if (st_q == S_H2 && rx_fire && data_ok) poison_q <= hdr_bad;
  end
`else
  assign data_ok = hit && sc_q && !hdr_bad;
  assign poison  = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    rx_ready_o  = 1'b0;
    cpl_valid_o = 1'b0;
    cpl_data_o  = '0;
    cpl_resp_o  = 2'b00;
    case (st_q)
      S_H0, S_H1: rx_ready_o = 1'b1;
      S_H2:       rx_ready_o = !alloc_valid_i;
      S_DATA: begin
        rx_ready_o  = cpl_ready_i && !alloc_valid_i;
        cpl_valid_o = rx_valid_i && !alloc_valid_i;
        cpl_data_o  = rx_data_i;
        cpl_resp_o  = poison ? 2'b10 : 2'b00;
      end
      S_ERROR: begin
        rx_ready_o  = !last_seen_q;
        cpl_valid_o = !alloc_valid_i;
        cpl_resp_o  = 2'b10;
      end
      S_FLUSH:    rx_ready_o = !last_seen_q;
      default:    ;
    endcase
  end

  assign cpl_last_o = ent.last;
  assign cpl_tag_o  = cur_tag_q;
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign cpl_fire   = cpl_valid_o && cpl_ready_i;
  assign set_unexp  = (st_q == S_H2 && rx_fire && !hit) ||
                      (st_q == S_DATA && cpl_fire && ent.last && !rx_last_i);
  assign set_to     = (st_q == S_TIMEOUT) && !alloc_valid_i;
  assign any_exp    = |exp_q;

  always_comb begin
    exp_idx = '0;
    for (int t = TAGS - 1; t >= 0; t--) if (exp_q[t]) exp_idx = TAG'(t);
  end

  // NOTE: the tag table maps to distributed RAM, so it has no reset; the allocator's init sweep clears it.
  always_ff @(posedge clk_i) begin
    if (alloc_we)
      mem[alloc_idx] <= '{valid: !alloc_init_i, last: (alloc_len_i == 10'd1),
                          addr: alloc_addr_i, len: alloc_len_i};
    else if (cpl_fire)
      mem[cur_tag_q] <= '{valid: !ent.last, last: (ent.len == 10'd2),
                          addr: ent.addr + 5'd1, len: ent.len - 10'd1};
  end

  assign tick    = (presc_q == PW'(TDIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // Activity on a tag (alloc or accepted word) restarts its age and beats a same-cycle tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < TAGS; t++) age_q[t] <= 2'd0;
      exp_q  <= '0;
      pend_q <= '0;
    end else begin
      for (int t = 0; t < TAGS; t++) begin
        if ((alloc_we && alloc_idx == TAG'(t)) || (cpl_fire && cur_tag_q == TAG'(t))) begin
          age_q[t] <= 2'd0;
          exp_q[t] <= 1'b0;
        end else begin
          if (tick && pend_q[t]) begin
            if (age_q[t] == 2'd3) exp_q[t] <= 1'b1;
            else                  age_q[t] <= age_q[t] + 2'd1;
          end
          if (set_to && cur_tag_q == TAG'(t)) exp_q[t] <= 1'b0;
        end
        if (alloc_we && alloc_idx == TAG'(t))                     pend_q[t] <= !alloc_init_i;
        else if (cpl_fire && ent.last && cur_tag_q == TAG'(t))    pend_q[t] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q        <= S_H0;
      cur_tag_q   <= '0;
      ep_q        <= 1'b0;
      err_q       <= 1'b0;
      sc_q        <= 1'b0;
      bcm_q       <= 1'b0;
      bc_q        <= '0;
      last_seen_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_unexp_q <= 1'b0;
      err_to_q    <= 1'b0;
      err_tag_q   <= '0;
      cplh_q      <= 1'b0;
      cpld_q      <= 1'b0;
    end else begin
      cplh_q <= cpl_fire && (ent.last || (rcb_i ? &ent.addr : &ent.addr[3:0]));
      cpld_q <= cpl_fire && (ent.last || &ent.addr[1:0]);
      if (set_unexp) begin
        err_valid_q <= 1'b1; err_unexp_q <= 1'b1; err_to_q <= 1'b0; err_tag_q <= '0;
      end else if (set_to) begin
        err_valid_q <= 1'b1; err_unexp_q <= 1'b0; err_to_q <= 1'b1; err_tag_q <= cur_tag_q;
      end else if (err_ready_i) begin
        err_valid_q <= 1'b0; err_unexp_q <= 1'b0; err_to_q <= 1'b0; err_tag_q <= '0;
      end
      if (rx_fire && rx_last_i) last_seen_q <= 1'b1;
      case (st_q)
        S_H0: begin
          last_seen_q <= 1'b0;
          if (rx_valid_i) begin
            ep_q  <= rx_data_i[14];
            err_q <= rx_err_i;
            st_q  <= S_H1;
          end else if (any_exp) begin
            cur_tag_q <= exp_idx;
            st_q      <= S_TIMEOUT;
          end
        end
        S_H1: if (rx_fire) begin
          sc_q  <= (rx_data_i[15:13] == 3'b000);
          bcm_q <= rx_data_i[12];
          bc_q  <= rx_data_i[11:0];
          err_q <= err_q || rx_err_i;
          st_q  <= S_H2;
        end
        S_H2: if (rx_fire) begin
          cur_tag_q <= rx_tag[TAG-1:0];
          if (data_ok)  st_q <= S_DATA;
          else if (hit) st_q <= S_ERROR;
          else          st_q <= S_FLUSH;
        end
        S_DATA: if (cpl_fire) begin
          if (rx_last_i)     st_q <= S_H0;
          else if (ent.last) st_q <= S_FLUSH;
        end
        S_ERROR:   if (cpl_fire && ent.last) st_q <= S_FLUSH;
        S_FLUSH:   if (last_seen_q && !err_valid_q) st_q <= S_H0;
        S_TIMEOUT: if (!alloc_valid_i) begin
          last_seen_q <= 1'b1;
          st_q        <= S_ERROR;
        end
        default:   st_q <= S_H0;
      endcase
    end
  end

  assign err_valid_o      = err_valid_q;
  assign err_unexpected_o = err_unexp_q;
  assign err_timeout_o    = err_to_q;
  assign err_tag_o        = err_tag_q;
  assign dealloc_cplh_o   = cplh_q;
  assign dealloc_cpld_o   = cpld_q;

endmodule
